// File: rtl/enemy_spawn_scheduler_pkg.sv
// Shared types and sizing for the enemy spawn scheduler: queue entry layout,
// FSM state encoding and slot/timestamp widths.
package spawn_pkg;
    localparam int SLOTS  = 8;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int TS_W   = 12;
    localparam int TYPE_W = 3;
    localparam int IDX_W  = 6;
    localparam logic [TYPE_W-1:0] END_TYPE = 3'd7;

    // One enemy queue ROM word: {timestamp, type}
    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [TYPE_W-1:0] kind;
    } spawn_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_DATA,
        S_WAIT_TIME,
        S_ALLOC,
        S_ISSUE,
        S_DONE
    } spawn_state_t;
endpackage

// File: rtl/enemy_spawn_scheduler_if.sv
// Spawn request handshake between the scheduler (master) and the Game_Engine
// enemy instance table (slave).
interface enemy_spawn_scheduler_if;
    import spawn_pkg::*;

    logic              valid;
    logic [SLOT_W-1:0] slot;
    logic [TYPE_W-1:0] kind;
    logic              ack;

    modport master (output valid, output slot, output kind, input ack);
    modport slave  (input valid, input slot, input kind, output ack);
endinterface

// File: rtl/enemy_spawn_scheduler_lowest_free_slot.sv
// Combinational priority encoder: index of the lowest set bit of a slot mask,
// plus a flag telling whether any bit is set at all.
module lowest_free_slot #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_mask,
    output logic [W-1:0] o_index,
    output logic         o_any
);
    // Scan from the top so the lowest set bit is the last one to win.
    always_comb begin
        o_index = '0;
        o_any   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_index = W'(i);
                o_any   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Walks the active level's enemy queue ROM, waits for each entry's timestamp,
// reserves the lowest free instance slot and hands a spawn request to the engine.
module enemy_spawn_scheduler
    import spawn_pkg::*;
(
    input  logic                    clk_25MHz,
    input  logic                    rst,
    input  logic                    i_level_start,
    input  logic [1:0]              i_level_sel,
    input  logic                    i_frame_tick,
    input  logic                    i_pause,
    input  logic [SLOTS-1:0]        i_enemy_exist,
    output logic [1+IDX_W:0]        o_rom_addr,
    input  logic [TS_W+TYPE_W-1:0]  i_rom_data,
    enemy_spawn_scheduler_if.master spawn,
    output logic [TS_W-1:0]         o_game_time,
    output logic                    o_queue_done
);
    spawn_state_t      r_state, w_state_next;
    logic [1:0]        r_level, w_level_next;
    logic [IDX_W-1:0]  r_idx, w_idx_next;
    spawn_entry_t      r_entry, w_entry_next;
    logic [TS_W-1:0]   r_game_time, w_game_time_next;
    logic [SLOTS-1:0]  r_reserved, w_reserved_next;
    logic              r_spawn_valid, w_spawn_valid_next;
    logic [SLOT_W-1:0] r_spawn_slot, w_spawn_slot_next;
    logic [TYPE_W-1:0] r_spawn_type, w_spawn_type_next;

    logic [SLOTS-1:0]  w_free;
    logic [SLOT_W-1:0] w_free_idx;
    logic              w_free_any;
    logic              w_restart;

    // A slot is usable only if the engine shows it empty and we have not
    // already handed it out while waiting for its exist bit to rise.
    assign w_free    = ~i_enemy_exist & ~r_reserved;
    assign w_restart = i_level_start && (i_level_sel != 2'd0);

    lowest_free_slot #(.N(SLOTS), .W(SLOT_W)) u_free (
        .i_mask  (w_free),
        .o_index (w_free_idx),
        .o_any   (w_free_any)
    );

    always_comb begin
        w_state_next       = r_state;
        w_level_next       = r_level;
        w_idx_next         = r_idx;
        w_entry_next       = r_entry;
        w_spawn_valid_next = r_spawn_valid;
        w_spawn_slot_next  = r_spawn_slot;
        w_spawn_type_next  = r_spawn_type;
        w_reserved_next    = r_reserved & ~i_enemy_exist;
        w_game_time_next   = r_game_time;

        if (r_state != S_IDLE && i_frame_tick && !i_pause && r_game_time != '1) begin
            w_game_time_next = r_game_time + 1'b1;
        end

        if (w_restart) begin
            // Restart wins over everything, including an ack landing this cycle.
            w_state_next       = S_FETCH;
            w_level_next       = i_level_sel - 2'd1;
            w_idx_next         = '0;
            w_game_time_next   = '0;
            w_reserved_next    = '0;
            w_spawn_valid_next = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_FETCH: w_state_next = S_WAIT_DATA;
                S_WAIT_DATA: begin
                    w_entry_next = spawn_entry_t'(i_rom_data);
                    w_state_next = (w_entry_next.kind == END_TYPE) ? S_DONE : S_WAIT_TIME;
                end
                S_WAIT_TIME: begin
                    if (r_game_time >= r_entry.ts && !i_pause) begin
                        w_state_next = S_ALLOC;
                    end
                end
                S_ALLOC: begin
                    if (w_free_any) begin
                        w_spawn_slot_next  = w_free_idx;
                        w_spawn_type_next  = r_entry.kind;
                        w_spawn_valid_next = 1'b1;
                        w_state_next       = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (spawn.ack) begin
                        w_spawn_valid_next            = 1'b0;
                        w_reserved_next[r_spawn_slot] = 1'b1;
                        // The last index parks in DONE rather than wrapping to entry 0.
                        if (r_idx == '1) begin
                            w_state_next = S_DONE;
                        end else begin
                            w_idx_next   = r_idx + 1'b1;
                            w_state_next = S_FETCH;
                        end
                    end
                end
                S_DONE: ;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_level       <= '0;
            r_idx         <= '0;
            r_entry       <= '0;
            r_game_time   <= '0;
            r_reserved    <= '0;
            r_spawn_valid <= 1'b0;
            r_spawn_slot  <= '0;
            r_spawn_type  <= '0;
        end else begin
            r_state       <= w_state_next;
            r_level       <= w_level_next;
            r_idx         <= w_idx_next;
            r_entry       <= w_entry_next;
            r_game_time   <= w_game_time_next;
            r_reserved    <= w_reserved_next;
            r_spawn_valid <= w_spawn_valid_next;
            r_spawn_slot  <= w_spawn_slot_next;
            r_spawn_type  <= w_spawn_type_next;
        end
    end

    assign o_rom_addr   = {r_level, r_idx};
    assign o_game_time  = r_game_time;
    assign o_queue_done = (r_state == S_DONE);
    assign spawn.valid  = r_spawn_valid;
    assign spawn.slot   = r_spawn_slot;
    assign spawn.kind   = r_spawn_type;
endmodule
